// File: rtl/cpu_pkg.sv
// Shared constants and fetch FSM encoding for the CPU front end.
package cpu_pkg;
    localparam int CPU_PC_W   = 12;
    localparam int CPU_INST_W = 19;
    localparam int FQ_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {instruction, pc+1}; head is combinational from storage, push/pop take effect next clk.
// Pop on empty is ignored; clear wins over push and pop; caller only pushes when an entry is free.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int PC_W   = CPU_PC_W,
    parameter int INST_W = CPU_INST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [INST_W-1:0]        pushInst,
    input  logic [PC_W-1:0]          pushPc,
    output logic                     headValid,
    output logic [INST_W-1:0]        headInst,
    output logic [PC_W-1:0]          headPc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INST_W-1:0] instMem [DEPTH];
    logic [PC_W-1:0]   pcMem   [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic              doPop;
    logic              doPush;
    logic              full;

    assign full      = (count == CNT_W'(DEPTH));
    assign doPop     = pop && (count != '0);
    assign doPush    = push && (!full || doPop);
    assign headValid = (count != '0);
    assign headInst  = instMem[rdPtr];
    assign headPc    = pcMem[rdPtr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instMem[i] <= '0;
                pcMem[i]   <= '0;
            end
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                instMem[wrPtr] <= pushInst;
                pcMem[wrPtr]   <= pushPc;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, single-outstanding req/ack instruction fetch and prefetch queue feeding IF/ID; min 2 clk fetch latency.
// Issue stalls while the queue is full or halt is high; IF/ID stall simply holds the queue head.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int PC_W   = CPU_PC_W,
    parameter int INST_W = CPU_INST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirectPc,
    input  logic                     ifIdWr,
    input  logic                     halt,
    output logic                     imemReq,
    output logic [PC_W-1:0]          imemAddr,
    input  logic                     imemAck,
    input  logic [INST_W-1:0]        imemData,
    output logic                     instValid,
    output logic [INST_W-1:0]        instOut,
    output logic [PC_W-1:0]          pcPlus1Out,
    output logic [$clog2(DEPTH):0]   queueCount
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    stateNext;
    logic [PC_W-1:0] fetchPc;
    logic [PC_W-1:0] fetchPcNext;
    logic [PC_W-1:0] reqAddr;
    logic [PC_W-1:0] pcPlus1;
    logic            push;
    logic            notFull;

    assign notFull = (queueCount != CNT_W'(DEPTH));
    assign pcPlus1 = fetchPc + 1'b1;

    // A redirect while waiting moves fetchPc, but the bus keeps showing the stale address until its ack.
    assign imemAddr = (state == DROP) ? reqAddr : fetchPc;

    always_comb begin
        stateNext   = state;
        fetchPcNext = fetchPc;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetchPcNext = redirectPc;
                end else if (!halt && notFull) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetchPcNext = redirectPc;
                    stateNext   = imemAck ? IDLE : DROP;
                end else if (imemAck) begin
                    push        = 1'b1;
                    fetchPcNext = pcPlus1;
                    stateNext   = IDLE;
                end
            end
            DROP: begin
                if (redirect) begin
                    fetchPcNext = redirectPc;
                end
                if (imemAck) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            fetchPc <= '0;
            reqAddr <= '0;
            imemReq <= 1'b0;
        end else begin
            state   <= stateNext;
            fetchPc <= fetchPcNext;
            imemReq <= (stateNext != IDLE);
            if (state == IDLE && stateNext == WAIT) begin
                reqAddr <= fetchPc;
            end
        end
    end

    fetch_queue #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (ifIdWr),
        .clear     (redirect),
        .pushInst  (imemData),
        .pushPc    (pcPlus1),
        .headValid (instValid),
        .headInst  (instOut),
        .headPc    (pcPlus1Out),
        .count     (queueCount)
    );
endmodule
